// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional build feature: define FETCH_STATS_EN to add the fetch statistics counters.
package fetch_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        FETCH = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} entries between fetch and decode.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// The head reads as zero while the FIFO is empty.
// With FETCH_STATS_EN defined, the current occupancy is exported as well.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
)
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  fetch_entry_t wdata,
    input  logic         pop,
    input  logic         clear,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
`ifdef FETCH_STATS_EN
    ,
    output logic [$clog2(DEPTH):0] count
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

`ifdef FETCH_STATS_EN
    assign count = wr_ptr - rd_ptr;
`endif

    // Pointer update; clear wins over any push or pop in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage write.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is not reset; stale slots are never visible because head is gated by empty.
        if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC register, FETCH/FAULT state machine, range checker
// and prefetch FIFO feeding decode over a valid/ready handshake.
// Optional build feature: FETCH_STATS_EN adds the stat_fetched / stat_flushed counters.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned MEM_SIZE = 1024,
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
)
(
    input  logic        clk,
    input  logic        reset_n,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        fetch_fault,
    output logic [63:0] fault_pc
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_flushed
`endif
);

    fetch_state_t state;
    fetch_state_t next_state;
    logic [63:0]  pc;
    logic [63:0]  pc_last_byte;
    logic         pc_ok;
    logic         push;
    logic         pop;
    logic         fifo_full;
    logic         fifo_empty;
    fetch_entry_t fifo_wdata;
    fetch_entry_t fifo_head;

    // A fetch is legal only when word aligned and the whole word lies inside the memory.
    assign pc_last_byte = pc + 64'(INSTR_BYTES - 1);
    assign pc_ok        = (pc[1:0] == 2'b00) && (pc_last_byte < 64'(MEM_SIZE));

    assign imem_addr  = pc;
    assign fifo_wdata = '{pc: pc, instr: imem_instr};
    assign out_valid  = ~fifo_empty;
    assign out_instr  = fifo_head.instr;
    assign out_pc     = fifo_head.pc;

`ifdef FETCH_STATS_EN
    logic [$clog2(DEPTH):0] occupancy;
`endif

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (fifo_wdata),
        .pop     (pop),
        .clear   (redirect_valid),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
`ifdef FETCH_STATS_EN
        ,
        .count   (occupancy)
`endif
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= FETCH;
        else          state <= next_state;
    end

    // Next state: a redirect always restarts fetching; a bad PC halts it.
    always_comb begin
        // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
        next_state = state;
        if (redirect_valid)                    next_state = FETCH;
        else if (state == FETCH && !pc_ok)     next_state = FAULT;
    end

    // Outputs and handshake strobes derived from the current state.
    always_comb begin
        fetch_fault = (state == FAULT);
        pop         = out_valid & out_ready & ~redirect_valid;
        push        = (state == FETCH) & pc_ok & (~fifo_full | pop) & ~redirect_valid;
    end

    // PC advance / redirect load, and capture of the faulting PC on FAULT entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc       <= RESET_PC;
            fault_pc <= '0;
        end else begin
            if (redirect_valid) pc <= redirect_pc;
            else if (push)      pc <= pc + 64'(INSTR_BYTES);
            if (state == FETCH && !redirect_valid && !pc_ok) fault_pc <= pc;
        end
    end

`ifdef FETCH_STATS_EN
    logic [32:0] flushed_sum;
    assign flushed_sum = {1'b0, stat_flushed} + 33'(occupancy);

    // Saturating counters: pushed words, and entries discarded by redirects.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_fetched <= '0;
            stat_flushed <= '0;
        end else begin
            if (push && stat_fetched != '1) stat_fetched <= stat_fetched + 32'd1;
            if (redirect_valid) stat_flushed <= flushed_sum[32] ? '1 : flushed_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a randomized
// run against a stream-level reference model of the fetch sequence.
module tb_instr_fetch_unit;

    localparam int unsigned MEM_SIZE = 1024;
    localparam int unsigned DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        fetch_fault;
    logic [63:0] fault_pc;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_flushed;
`endif

    logic [31:0] rom [256];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb imem_instr = rom[imem_addr[9:2]];

    instr_fetch_unit #(
        .MEM_SIZE (MEM_SIZE),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fetch_fault    (fetch_fault),
        .fault_pc       (fault_pc)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched   (stat_fetched),
        .stat_flushed   (stat_flushed)
`endif
    );

    // Legal fetch address: word aligned and the full word inside memory.
    function automatic bit pc_is_ok(input logic [63:0] a);
        return (a % 4 == 0) && (a + 3 < 64'(MEM_SIZE));
    endfunction

    // First address on the sequential path from s that cannot be fetched.
    function automatic logic [63:0] first_bad(input logic [63:0] s);
        logic [63:0] a = s;
        for (int k = 0; k < 400 && pc_is_ok(a); k++) a = a + 4;
        return a;
    endfunction

    function automatic logic [31:0] rom_at(input logic [63:0] a);
        return rom[a[9:2]];
    endfunction

    // Holds reset low for two cycles with idle inputs; caller releases it on a falling edge.
    task automatic hold_reset();
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic do_redirect(input logic [63:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        hold_reset();
        checks++;
        if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 64'h0 ||
            fetch_fault !== 1'b0 || fault_pc !== 64'h0 || imem_addr !== RESET_PC) begin
            failures++;
            $display("FAIL reset_values: got valid=%b instr=%h pc=%h fault=%b fault_pc=%h addr=%h, expected 0,0,0,0,0,%h",
                     out_valid, out_instr, out_pc, fetch_fault, fault_pc, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        hold_reset();
        out_ready = 1'b1;
        reset_n   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 64'(4 * i) || out_instr !== rom[i]) begin
                failures++;
                $display("FAIL stream_word%0d: got valid=%b pc=%h instr=%h, expected 1 %h %h",
                         i, out_valid, out_pc, out_instr, 64'(4 * i), rom[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        hold_reset();
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (imem_addr !== 64'd16 || out_valid !== 1'b1 || out_pc !== 64'd0) begin
            failures++;
            $display("FAIL backpressure_hold: got addr=%h valid=%b head=%h, expected 10 1 0",
                     imem_addr, out_valid, out_pc);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 64'(4 * i) || out_instr !== rom[i]) begin
                failures++;
                $display("FAIL backpressure_drain%0d: got valid=%b pc=%h instr=%h, expected 1 %h %h",
                         i, out_valid, out_pc, out_instr, 64'(4 * i), rom[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect_flush();
        hold_reset();
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (out_pc !== 64'd0 || imem_addr !== 64'd12) begin
            failures++;
            $display("FAIL flush_setup: got head=%h addr=%h, expected 0 c", out_pc, imem_addr);
        end
        out_ready = 1'b1;
        do_redirect(64'h40);
        checks++;
        if (out_valid !== 1'b0 || imem_addr !== 64'h40) begin
            failures++;
            $display("FAIL flush_empty: got valid=%b addr=%h, expected 0 40", out_valid, imem_addr);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h40 || out_instr !== rom[16]) begin
            failures++;
            $display("FAIL flush_target: got valid=%b pc=%h instr=%h, expected 1 40 %h",
                     out_valid, out_pc, out_instr, rom[16]);
        end
    endtask

    task automatic test_range_fault();
        out_ready = 1'b1;
        do_redirect(64'h3FC);
        checks++;
        if (imem_addr !== 64'h3FC || fetch_fault !== 1'b0) begin
            failures++;
            $display("FAIL range_addr: got addr=%h fault=%b, expected 3fc 0", imem_addr, fetch_fault);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h3FC || out_instr !== rom[255] || fetch_fault !== 1'b0) begin
            failures++;
            $display("FAIL range_last_word: got valid=%b pc=%h instr=%h fault=%b, expected 1 3fc %h 0",
                     out_valid, out_pc, out_instr, fetch_fault, rom[255]);
        end
        @(negedge clk);
        checks++;
        if (fetch_fault !== 1'b1 || fault_pc !== 64'h400 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL range_fault: got fault=%b fault_pc=%h valid=%b, expected 1 400 0",
                     fetch_fault, fault_pc, out_valid);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (fetch_fault !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 64'h400) begin
            failures++;
            $display("FAIL range_stays: got fault=%b valid=%b addr=%h, expected 1 0 400",
                     fetch_fault, out_valid, imem_addr);
        end
        do_redirect(64'h8);
        checks++;
        if (fetch_fault !== 1'b0 || imem_addr !== 64'h8) begin
            failures++;
            $display("FAIL range_recover: got fault=%b addr=%h, expected 0 8", fetch_fault, imem_addr);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h8 || out_instr !== rom[2]) begin
            failures++;
            $display("FAIL range_resume: got valid=%b pc=%h instr=%h, expected 1 8 %h",
                     out_valid, out_pc, out_instr, rom[2]);
        end
    endtask

    task automatic test_misaligned();
        out_ready = 1'b1;
        do_redirect(64'h6);
        @(negedge clk);
        checks++;
        if (fetch_fault !== 1'b1 || fault_pc !== 64'h6 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL misaligned_fault: got fault=%b fault_pc=%h valid=%b, expected 1 6 0",
                     fetch_fault, fault_pc, out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || imem_addr !== 64'h6) begin
            failures++;
            $display("FAIL misaligned_nopush: got valid=%b addr=%h, expected 0 6", out_valid, imem_addr);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        do_redirect(64'h3F0);
        repeat (6) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h3F0 || fetch_fault !== 1'b1 || fault_pc !== 64'h400) begin
            failures++;
            $display("FAIL async_setup: got valid=%b head=%h fault=%b fault_pc=%h, expected 1 3f0 1 400",
                     out_valid, out_pc, fetch_fault, fault_pc);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || fetch_fault !== 1'b0 || imem_addr !== RESET_PC || fault_pc !== 64'h0) begin
            failures++;
            $display("FAIL async_reset: got valid=%b fault=%b addr=%h fault_pc=%h, expected 0 0 %h 0",
                     out_valid, fetch_fault, imem_addr, fault_pc, RESET_PC);
        end
`ifdef FETCH_STATS_EN
        checks++;
        if (stat_fetched !== 32'h0 || stat_flushed !== 32'h0) begin
            failures++;
            $display("FAIL async_stats: got fetched=%0d flushed=%0d, expected 0 0", stat_fetched, stat_flushed);
        end
`endif
        @(negedge clk);
    endtask

    // Random ready/redirect traffic; the model predicts the delivered PC stream and the fault address.
    task automatic test_random();
        logic [63:0] exp_next;
        logic [63:0] exp_fault;
        logic [63:0] target;
        bit          after_redirect = 1'b0;
        bit          ready;
        bit          redir;
        int          delivered = 0;
        int unsigned sel;

        hold_reset();
        reset_n   = 1'b1;
        exp_next  = RESET_PC;
        exp_fault = first_bad(RESET_PC);
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            if (after_redirect) begin
                checks++;
                if (out_valid !== 1'b0 || fetch_fault !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_post_redirect cyc%0d: got valid=%b fault=%b, expected 0 0",
                             cyc, out_valid, fetch_fault);
                end
                after_redirect = 1'b0;
            end
            if (fetch_fault === 1'b1) begin
                checks++;
                if (fault_pc !== exp_fault) begin
                    failures++;
                    $display("FAIL rand_fault_pc cyc%0d: got %h expected %h", cyc, fault_pc, exp_fault);
                end
            end
            ready = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 24) == 0);
            if (out_valid === 1'b1 && ready && !redir) begin
                checks++;
                if (!pc_is_ok(exp_next) || out_pc !== exp_next || out_instr !== rom_at(exp_next)) begin
                    failures++;
                    $display("FAIL rand_transfer cyc%0d: got pc=%h instr=%h, expected pc=%h instr=%h (legal=%0d)",
                             cyc, out_pc, out_instr, exp_next, rom_at(exp_next), pc_is_ok(exp_next));
                end
                exp_next = exp_next + 4;
                delivered++;
            end
            out_ready      = ready;
            redirect_valid = redir;
            if (redir) begin
                sel = $urandom_range(0, 9);
                if (sel < 6)      target = 64'($urandom_range(0, 255)) << 2;
                else if (sel < 8) target = 64'($urandom_range(248, 255)) << 2;
                else              target = (64'($urandom_range(0, 255)) << 2) | 64'($urandom_range(1, 3));
                redirect_pc    = target;
                exp_next       = target;
                exp_fault      = first_bad(target);
                after_redirect = 1'b1;
            end
        end
        redirect_valid = 1'b0;
        checks++;
        if (delivered < 50) begin
            failures++;
            $display("FAIL rand_throughput: got %0d transfers, expected at least 50", delivered);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_range_fault();
        test_misaligned();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
